// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   mdu_op_e : operation encodings carried on the 3-bit op port.
//   state_e  : sequencer states of mdu_iter.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on magnitudes.
// Ports:
//   i_rem     - partial remainder entering the step (always < divisor, or
//               any value when the divisor is zero)
//   i_bit     - next dividend bit shifted into the remainder
//   i_divisor - divisor magnitude
//   o_rem     - partial remainder leaving the step
//   o_q       - quotient bit produced by this step
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  // One extra bit holds the shifted remainder; since i_rem < divisor the
  // restored or subtracted result always fits back into WIDTH bits.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q     = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO registers.
// Signed operations work on magnitudes and fix the sign in a final cycle.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   start     - operation request, sampled only while idle
//   op        - MULT/MULTU/DIV/DIVU/MTHI/MTLO select (mdu_pkg encodings)
//   a, b      - operands (a is also the MTHI/MTLO source)
//   busy      - high while a multiply/divide is iterating
//   done      - one-cycle pulse coinciding with the hi/lo update
//   div_zero  - valid with done: the finished divide had a zero divisor
//   hi, lo    - HI/LO registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  // Upper half: product high / partial remainder.
  // Lower half: multiplier being consumed / dividend becoming the quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic               r_neg_res;   // signed op with differing operand signs
  logic               r_neg_rem;   // signed divide with a negative dividend
  logic               r_is_div;
  logic               r_bzero;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  mdu_op_e            w_op;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_q;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op     = mdu_op_e'(op);
  assign w_is_mul = (w_op == MDU_MULT) || (w_op == MDU_MULTU);
  assign w_is_div = (w_op == MDU_DIV)  || (w_op == MDU_DIVU);
  assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Shift-add multiply: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_bit     (r_acc[WIDTH-1]),
    .i_divisor (r_opnd),
    .o_rem     (w_div_rem),
    .o_q       (w_div_q)
  );

  assign w_div_nxt = {w_div_rem, r_acc[WIDTH-2:0], w_div_q};

  // With a zero divisor the remainder path yields |a|, and restoring the
  // dividend sign reproduces a exactly, so only lo needs an override.
  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_bzero   ? {WIDTH{1'b1}}
                    : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH]
                                : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_is_mul)      w_state_nxt = S_MUL;
          else if (w_is_div) w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == LAST) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_is_div   <= 1'b0;
      r_bzero    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      // busy is asserted by the iteration edges themselves, so it is high
      // for exactly WIDTH cycles and drops as done rises.
      r_busy     <= (r_state == S_MUL) || (r_state == S_DIV);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul || w_is_div) begin
              r_cnt     <= '0;
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_is_div  <= w_is_div;
              r_bzero   <= (b == '0);
              if (w_is_mul) begin
                r_opnd <= w_a_mag;
                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
              end else begin
                r_opnd <= w_b_mag;
                r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
              end
            end else if (w_op == MDU_MTHI) begin
              r_hi <= a;
            end else if (w_op == MDU_MTLO) begin
              r_lo <= a;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done     <= 1'b1;
          r_div_zero <= r_is_div & r_bzero;
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit for the MIPS datapath; it sits beside the single-cycle ALU and owns the HI/LO registers. Supports signed and unsigned multiply and divide, plus direct writes to HI and LO. Uses a start/busy/done handshake so the control unit can stall while an operation runs.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO.
CNT_W, 6, iteration-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  3  operation select: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; others reserved.
a  in  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO source).
b  in  WIDTH  operand B (multiplier or divisor).
busy  out  1  high while a multiply or divide is in progress.
done  out  1  one-cycle pulse; hi/lo are updated when it is high.
div_zero  out  1  registered with done; high when the finishing DIV/DIVU had b==0.
hi  out  WIDTH  HI register (upper product or remainder).
lo  out  WIDTH  LO register (lower product or quotient).

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst). It is decided, not optional.
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- Reset mid-operation: abort at the next edge and apply the reset values. The partial result is discarded.
- States:
  - IDLE: wait for start.
  - MUL: WIDTH shift-add steps.
  - DIV: WIDTH restoring-division steps.
  - FIX: sign correction; commit hi/lo.
- IDLE, start=1, op=MULT/MULTU: latch operand magnitudes (signed ops take the absolute value) and the sign flags. Clear the accumulator, counter=0. Go to MUL; busy=1 from the next cycle.
- IDLE, start=1, op=DIV/DIVU: latch operands as for multiply. Go to DIV; busy=1.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= a at that edge. busy stays 0 and done is not pulsed.
- IDLE, start=1, reserved op: ignored; no state change.
- MUL/DIV: one step per cycle with the counter incrementing. After the step where counter==WIDTH-1, go to FIX.
- FIX:
  - Multiply: negate the 2*WIDTH product if the signs differed (signed only). Write {hi,lo}.
  - Divide: lo=quotient, negated if the signs differed (signed only); hi=remainder, carrying the sign of the dividend.
  - Then done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start sampled at edge k. done and the new hi/lo are visible after edge k+WIDTH+1, i.e. WIDTH+1 cycles. busy is high for WIDTH cycles, then falls in the same cycle done rises.
- Back-to-back: start may be high in the done cycle. It is sampled, since state is IDLE, and begins the next operation.
- start while busy: ignored; operands and op are not re-latched.
- hi/lo hold their previous values throughout an operation. They change only at FIX, MTHI/MTLO, or reset.
- Divide by zero (b==0, either divide): lo=all ones, hi=a (unmodified dividend), div_zero=1. Full latency still applies, so timing is uniform.
- Signed overflow (DIV, a=-2**(WIDTH-1), b=-1): lo=-2**(WIDTH-1), hi=0, div_zero=0.
- Width rules: the product is the exact 2*WIDTH result. Quotient and remainder are exact WIDTH values. There are no overflow or exception outputs.
- Outputs busy, done, div_zero, hi and lo are all registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO;
  - state encodings S_IDLE, S_MUL, S_DIV, S_FIX.
- One natural sub-module: mdu_div_step. It is a combinational single restoring-division step: remainder and dividend-shift in; next remainder and quotient bit out.
- The multiply step stays inline.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 32 cycles.
- MULT, a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU, a=100, b=7 -> lo=14, hi=2.
- DIVU, a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1 for one cycle. Then DIV, a=0x80000000, b=-1 -> lo=0x80000000, hi=0, div_zero=0.
- MTHI a=0xA5A5A5A5, then start with MULTU 5x6 held through busy plus a second start mid-operation -> second start ignored; hi=0xA5A5A5A5 until done, then hi=0, lo=30. A start asserted in the done cycle begins a new operation.
- rst asserted at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0, state IDLE. No done pulse follows; a fresh MULTU 2x3 afterwards gives lo=6.
